sfx_sequencer: RTL and testbench

- Sound-effect scheduler that owns the single `audio` output of the game.
- Arbitrates one-cycle event pulses from the game controller (flap, score, coin, crash) by fixed priority.
- Sequences the winning effect's note list from an internal ROM and produces a square wave for the buzzer pin.
- Sits between `control` and the top-level `audio` output; replaces the tied-off audio.

---
 rtl/sfx_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_sfx_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_sequencer.sv
// Sound-effect scheduler: picks the highest-priority event request, walks the
// effect's note list from a small ROM and drives a square wave onto the buzzer.
module sfx_sequencer #(
   parameter int unsigned TICK_DIV    = 100000,
   parameter int unsigned GAP_TICKS   = 10,
   parameter int unsigned PITCH_SHIFT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_flap,
   input  logic       req_score,
   input  logic       req_coin,
   input  logic       req_crash,
   input  logic       mute,
   output logic       audio,
   output logic       busy,
   output logic [2:0] cur_fx,
   output logic       done
);

   localparam int unsigned HP_W  = 18;
   localparam int unsigned CYC_W = 32;
   localparam int unsigned FX_W  = 3;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned DUR_W = 8;

   localparam logic [CYC_W-1:0] GAP_CYC = CYC_W'(GAP_TICKS * TICK_DIV);

   localparam logic [FX_W-1:0] FX_NONE  = FX_W'(0);
   localparam logic [FX_W-1:0] FX_FLAP  = FX_W'(1);
   localparam logic [FX_W-1:0] FX_SCORE = FX_W'(2);
   localparam logic [FX_W-1:0] FX_COIN  = FX_W'(3);
   localparam logic [FX_W-1:0] FX_CRASH = FX_W'(4);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [FX_W-1:0]    fx_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [HP_W-1:0]    hp_q, hp_d;
   logic               phase_q, phase_d;
   logic               audio_d, busy_d, done_d;

   logic [FX_W-1:0]    req_fx;
   logic [HP_W-1:0]    rom_hp;
   logic [DUR_W-1:0]   rom_dur;
   logic               rom_last;
   logic [HP_W-1:0]    hp_shift;
   logic [HP_W-1:0]    hp_top;
   logic [CYC_W-1:0]   note_cyc;
   logic               note_end;
   logic               fx_end;

   // Fixed priority: the effect code doubles as its priority rank.
   always_comb begin
      req_fx = FX_NONE;
      if (req_crash)      req_fx = FX_CRASH;
      else if (req_coin)  req_fx = FX_COIN;
      else if (req_score) req_fx = FX_SCORE;
      else if (req_flap)  req_fx = FX_FLAP;
   end

   // Note ROM: half-period in cycles and duration in ticks per (effect, note).
   always_comb begin
      rom_hp   = HP_W'(1);
      rom_dur  = DUR_W'(0);
      rom_last = 1'b1;
      case ({cur_fx, idx_q})
         {FX_FLAP,  2'd0}: begin rom_hp = 18'd63776;  rom_dur = 8'd40; end
         {FX_SCORE, 2'd0}: begin rom_hp = 18'd75873;  rom_dur = 8'd60; rom_last = 1'b0; end
         {FX_SCORE, 2'd1}: begin rom_hp = 18'd47756;  rom_dur = 8'd60; end
         {FX_COIN,  2'd0}: begin rom_hp = 18'd75873;  rom_dur = 8'd40; rom_last = 1'b0; end
         {FX_COIN,  2'd1}: begin rom_hp = 18'd63776;  rom_dur = 8'd40; rom_last = 1'b0; end
         {FX_COIN,  2'd2}: begin rom_hp = 18'd47756;  rom_dur = 8'd80; end
         {FX_CRASH, 2'd0}: begin rom_hp = 18'd113636; rom_dur = 8'd100; rom_last = 1'b0; end
         {FX_CRASH, 2'd1}: begin rom_hp = 18'd227273; rom_dur = 8'd200; end
         default: ;
      endcase
   end

   always_comb begin
      hp_shift = rom_hp >> PITCH_SHIFT;
      hp_top   = (hp_shift == HP_W'(0)) ? HP_W'(0) : hp_shift - 1'b1;
      note_cyc = CYC_W'(rom_dur) * CYC_W'(TICK_DIV);
      note_end = (state_q == PLAY) && (cyc_q == note_cyc - 1'b1);
      fx_end   = note_end && rom_last;
   end

   always_comb begin
      state_d = state_q;
      fx_d    = cur_fx;
      idx_d   = idx_q;
      cyc_d   = cyc_q + 1'b1;
      hp_d    = hp_q;
      phase_d = phase_q;
      busy_d  = busy;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            cyc_d = '0;
         end
         PLAY: begin
            if (hp_q == hp_top) begin
               hp_d    = '0;
               phase_d = ~phase_q;
            end else begin
               hp_d = hp_q + 1'b1;
            end
            if (note_end) begin
               cyc_d   = '0;
               hp_d    = '0;
               phase_d = 1'b0;
               if (rom_last) begin
                  state_d = IDLE;
                  fx_d    = FX_NONE;
                  idx_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            phase_d = 1'b0;
            if (cyc_q == GAP_CYC - 1'b1) begin
               state_d = PLAY;
               idx_d   = idx_q + 1'b1;
               cyc_d   = '0;
               hp_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // New effect from idle, by strict-priority preemption, or on the finishing edge.
      if ((req_fx != FX_NONE) &&
          ((state_q == IDLE) || (req_fx > cur_fx) || fx_end)) begin
         state_d = PLAY;
         fx_d    = req_fx;
         idx_d   = '0;
         cyc_d   = '0;
         hp_d    = '0;
         phase_d = 1'b0;
         busy_d  = 1'b1;
      end

      audio_d = phase_d & ~mute;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cur_fx  <= FX_NONE;
         idx_q   <= '0;
         cyc_q   <= '0;
         hp_q    <= '0;
         phase_q <= 1'b0;
         audio   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_fx  <= fx_d;
         idx_q   <= idx_d;
         cyc_q   <= cyc_d;
         hp_q    <= hp_d;
         phase_q <= phase_d;
         audio   <= audio_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: per-cycle comparison against a note-list timing model.
module tb_sfx_sequencer;

   localparam int unsigned TD = 10;
   localparam int unsigned GT = 10;
   localparam int unsigned PS = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_flap = 1'b0, req_score = 1'b0, req_coin = 1'b0, req_crash = 1'b0;
   logic       mute = 1'b0;
   logic       audio, busy, done;
   logic [2:0] cur_fx;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: active flag, effect, cycle index since the effect's first PLAY cycle.
   logic       m_act = 1'b0;
   int         m_fx  = 0;
   int         m_t   = 0;
   logic [5:0] exp_v;
   logic [5:0] obs_v;

   sfx_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GT), .PITCH_SHIFT(PS)) dut (
      .clk(clk), .rst(rst),
      .req_flap(req_flap), .req_score(req_score), .req_coin(req_coin), .req_crash(req_crash),
      .mute(mute), .audio(audio), .busy(busy), .cur_fx(cur_fx), .done(done)
   );

   always #5 clk = ~clk;

   function automatic int n_notes(input int fx);
      case (fx)
         1: return 1;
         2: return 2;
         3: return 3;
         4: return 2;
         default: return 0;
      endcase
   endfunction

   function automatic int note_hp(input int fx, input int i);
      int raw;
      case (fx * 4 + i)
         4:  raw = 63776;
         8:  raw = 75873;
         9:  raw = 47756;
         12: raw = 75873;
         13: raw = 63776;
         14: raw = 47756;
         16: raw = 113636;
         17: raw = 227273;
         default: raw = 1;
      endcase
      raw = raw >> PS;
      return (raw == 0) ? 1 : raw;
   endfunction

   function automatic int note_len(input int fx, input int i);
      int d;
      case (fx * 4 + i)
         4: d = 40;   8: d = 60;   9: d = 60;
         12: d = 40;  13: d = 40;  14: d = 80;
         16: d = 100; 17: d = 200;
         default: d = 0;
      endcase
      return d * TD;
   endfunction

   function automatic int fx_total(input int fx);
      int s = 0;
      for (int i = 0; i < n_notes(fx); i++) s += note_len(fx, i);
      return s + (n_notes(fx) - 1) * GT * TD;
   endfunction

   function automatic logic wave(input int fx, input int t);
      int off = t;
      for (int i = 0; i < n_notes(fx); i++) begin
         if (off < note_len(fx, i)) return ((off / note_hp(fx, i)) % 2) == 1;
         off -= note_len(fx, i);
         if (off < GT * TD) return 1'b0;
         off -= GT * TD;
      end
      return 1'b0;
   endfunction

   // Drive one cycle of inputs, clock them in, advance the model, settle for sampling.
   task automatic step(input logic [3:0] req, input logic m, input logic r);
      int   w;
      logic ended;
      logic e_done;
      {req_crash, req_coin, req_score, req_flap} = req;
      mute = m;
      rst  = r;
      @(posedge clk);
      w = req[3] ? 4 : req[2] ? 3 : req[1] ? 2 : req[0] ? 1 : 0;
      e_done = 1'b0;
      if (r) begin
         m_act = 1'b0; m_fx = 0; m_t = 0;
      end else if (m_act) begin
         ended = (m_t == fx_total(m_fx) - 1);
         e_done = ended;
         if (w > m_fx || (ended && w != 0)) begin
            m_fx = w; m_t = 0;
         end else if (ended) begin
            m_act = 1'b0; m_fx = 0; m_t = 0;
         end else begin
            m_t++;
         end
      end else if (w != 0) begin
         m_act = 1'b1; m_fx = w; m_t = 0;
      end
      exp_v = {m_act ? (wave(m_fx, m_t) & ~m) : 1'b0, m_act, 3'(m_fx), e_done};
      #1;
      obs_v = {audio, busy, cur_fx, done};
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(4'b0000, 1'b0, 1'b1);
         n_checks++;
         if (obs_v !== 6'b0) begin
            n_errors++;
            $display("FAIL reset cyc%0d: got %b want %b", i, obs_v, 6'b0);
         end
      end
      step(4'b0000, 1'b0, 1'b0);
   endtask

   task automatic test_flap();
      int toggles = 0, busy_n = 0, done_n = 0;
      logic prev = 1'b0;
      for (int i = 0; i < 410; i++) begin
         step((i == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
         n_checks++;
         if (obs_v !== exp_v) begin
            n_errors++;
            $display("FAIL flap cyc%0d {audio,busy,fx,done}: got %b want %b", i, obs_v, exp_v);
         end
         if (busy === 1'b1 && audio !== prev) toggles++;
         prev = audio;
         busy_n += (busy === 1'b1) ? 1 : 0;
         done_n += (done === 1'b1) ? 1 : 0;
      end
      n_checks++;
      if (toggles != 6 || busy_n != 400 || done_n != 1) begin
         n_errors++;
         $display("FAIL flap_totals: got toggles=%0d busy=%0d done=%0d want 6/400/1",
                  toggles, busy_n, done_n);
      end
   endtask

   // Run one scripted scenario: req_a at cycle 0, req_b at cycle at_b, optional mute/reset.
   task automatic run_scn(input string name, input logic [3:0] req_a, input logic [3:0] req_b,
                          input int at_b, input int ncyc, input logic m, input int rst_at,
                          input int want_busy, input int want_done);
      int busy_n = 0, done_n = 0;
      for (int i = 0; i < ncyc; i++) begin
         step((i == 0) ? req_a : (i == at_b) ? req_b : 4'b0000, m, i == rst_at);
         n_checks++;
         if (obs_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s cyc%0d {audio,busy,fx,done}: got %b want %b", name, i, obs_v, exp_v);
         end
         busy_n += (busy === 1'b1) ? 1 : 0;
         done_n += (done === 1'b1) ? 1 : 0;
      end
      n_checks++;
      if (busy_n != want_busy || done_n != want_done) begin
         n_errors++;
         $display("FAIL %s_totals: got busy=%0d done=%0d want %0d/%0d",
                  name, busy_n, done_n, want_busy, want_done);
      end
   endtask

   task automatic test_score();
      run_scn("score", 4'b0010, 4'b0000, -1, 1310, 1'b0, -1, 1300, 1);
   endtask

   task automatic test_preempt();
      run_scn("preempt", 4'b0001, 4'b0100, 100, 1910, 1'b0, -1, 1900, 1);
   endtask

   task automatic test_priority_drop();
      int at = 1 + int'($urandom_range(2998));
      run_scn("prio", 4'b0110, 4'b0000, -1, 1810, 1'b0, -1, 1800, 1);
      run_scn("drop", 4'b1000, 4'b0001, at, 3110, 1'b0, -1, 3100, 1);
   endtask

   task automatic test_mute();
      run_scn("mute", 4'b0100, 4'b0000, -1, 1810, 1'b1, -1, 1800, 1);
   endtask

   task automatic test_back_to_back();
      run_scn("collide", 4'b0010, 4'b0001, 1300, 1710, 1'b0, -1, 1700, 2);
   endtask

   task automatic test_reset_mid();
      int at = 500 + int'($urandom_range(2000));
      run_scn("rst_mid", 4'b1000, 4'b0000, -1, 3110, 1'b0, at, at, 0);
   endtask

   task automatic test_random();
      logic [3:0] req;
      logic       m = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         req = '0;
         for (int b = 0; b < 4; b++) req[b] = ($urandom_range(299) == 0);
         if ($urandom_range(49) == 0) m = ~m;
         step(req, m, $urandom_range(2999) == 0);
         n_checks++;
         if (obs_v !== exp_v) begin
            n_errors++;
            $display("FAIL random cyc%0d {audio,busy,fx,done}: got %b want %b", i, obs_v, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_flap();
      test_score();
      test_preempt();
      test_priority_drop();
      test_mute();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
